// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// The optional skid entry is enabled by defining EX_MEM_PIPE_SKID_EN.
package ex_mem_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;
  localparam int CTRL_W     = 4;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
  } ctrl_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ex_mem_slot.sv
// One payload register with load enable and valid clear.
// Load takes priority over clear; the payload is kept on clear so a bubble holds the last value.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         vld
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (load) begin
      q   <= d;
      vld <= 1'b1;
    end else if (clear) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake and flush.
// Define EX_MEM_PIPE_SKID_EN for a second (skid) entry and a registered ready_o.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic [REG_AW-1:0] rd_addr_o
);

  localparam int PW = CTRL_W + 2*XLEN + REG_AW;

  logic [PW-1:0] in_pl, head_d, head_q;
  logic          head_vld, head_ld, head_clr;
  logic          accept, drain;
  occ_e          occ;
  ctrl_t         head_ctrl;

  assign in_pl  = {ctrl_i, alu_result_i, rs2_data_i, rd_addr_i};
  assign drain  = head_vld && ready_i;
  // Flush beats accept: an instruction offered alongside a flush is dropped.
  assign accept = valid_i && ready_o && !flush_i;

`ifdef EX_MEM_PIPE_SKID_EN
  logic [PW-1:0] skid_q;
  logic          skid_vld, skid_ld, skid_clr;

  assign ready_o = !skid_vld;
  assign occ     = skid_vld ? OCC_TWO : (head_vld ? OCC_ONE : OCC_EMPTY);
  assign head_d  = skid_vld ? skid_q : in_pl;

  ex_mem_slot #(.W(PW)) u_skid (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (skid_ld),
    .clear (skid_clr),
    .d     (in_pl),
    .q     (skid_q),
    .vld   (skid_vld)
  );
`else
  assign ready_o = !head_vld || ready_i;
  assign occ     = head_vld ? OCC_ONE : OCC_EMPTY;
  assign head_d  = in_pl;
`endif

  always_comb begin
    head_ld  = 1'b0;
    head_clr = 1'b0;
`ifdef EX_MEM_PIPE_SKID_EN
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
`endif
    if (flush_i) begin
      head_clr = 1'b1;
`ifdef EX_MEM_PIPE_SKID_EN
      skid_clr = 1'b1;
`endif
    end else begin
      case (occ)
        OCC_EMPTY: head_ld = accept;
        OCC_ONE: begin
          if (accept && drain)  head_ld = 1'b1;
`ifdef EX_MEM_PIPE_SKID_EN
          else if (accept)      skid_ld = 1'b1;
`endif
          else if (drain)       head_clr = 1'b1;
        end
`ifdef EX_MEM_PIPE_SKID_EN
        // Skid entry advances into the head on the same edge the head drains.
        OCC_TWO: begin
          if (drain) begin
            head_ld  = 1'b1;
            skid_clr = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  ex_mem_slot #(.W(PW)) u_head (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (head_ld),
    .clear (head_clr),
    .d     (head_d),
    .q     (head_q),
    .vld   (head_vld)
  );

  assign head_ctrl  = head_q[PW-1 -: CTRL_W];
  assign valid_o    = head_vld;
  assign ctrl_o     = head_vld ? head_ctrl : '0;
  assign mem_addr_o = head_q[2*XLEN+REG_AW-1 -: XLEN];
  assign mem_data_o = head_q[XLEN+REG_AW-1 -: XLEN];
  assign rd_addr_o  = head_q[REG_AW-1:0];

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of the ALU result and store data.
REQ-002 Parameter REG_AW, default 5, SHALL set the width of the destination register address.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset, asynchronous and active-high.
REQ-005 flush_i  in  1  SHALL request that all held instructions be discarded.
REQ-006 valid_i  in  1  SHALL qualify an upstream (EX) instruction.
REQ-007 ready_o  out  1  SHALL indicate that the block accepts an instruction this cycle.
REQ-008 ctrl_i  in  4  SHALL carry {RegWrite, MemToReg, MemRead, MemWrite}.
REQ-009 alu_result_i  in  XLEN; rs2_data_i  in  XLEN; rd_addr_i  in  REG_AW -- SHALL be captured alongside ctrl_i.
REQ-010 valid_o  out  1  SHALL qualify the downstream (MEM) instruction.
REQ-011 ready_i  in  1  SHALL indicate that MEM consumes the output this cycle.
REQ-012 ctrl_o  out  4; mem_addr_o  out  XLEN (from alu_result); mem_data_o  out  XLEN (from rs2_data); rd_addr_o  out  REG_AW -- SHALL present the head entry.

Function
REQ-013 Accept SHALL occur when valid_i && ready_o; drain SHALL occur when valid_o && ready_i.
REQ-014 Latency from accept to valid_o SHALL be exactly 1 cycle when the block was empty.
REQ-015 Order SHALL be preserved, with no loss or duplication of any accepted instruction.
REQ-016 ctrl_o SHALL be 4'b0 whenever valid_o=0, so a bubble is a guaranteed no-op; the other outputs hold their last value.
REQ-017 Simultaneous accept and drain with one entry held SHALL replace the head with no bubble, giving full throughput.
REQ-018 flush_i=1 SHALL invalidate all entries at the next edge; an instruction offered in the same cycle SHALL be dropped (flush beats accept); valid_o=0 the following cycle.
REQ-019 Output payload SHALL be stable while valid_o=1 and ready_i=0.
REQ-020 Occupancy states: EMPTY, ONE, TWO (TWO only with skid enabled). Transitions:
- EMPTY->ONE on accept.
- ONE->EMPTY on drain without accept.
- ONE->TWO on accept without drain.
- TWO->ONE on drain (the skid entry moves to the head in the same edge).
- Any state->EMPTY on flush_i.

Reset
REQ-021 rst_i SHALL force EMPTY, valid_o=0, ctrl_o=0, mem_addr_o=0, mem_data_o=0, rd_addr_o=0, and clear the skid entry, asynchronously.
REQ-022 After rst_i deasserts, ready_o SHALL be 1 in the first cycle.
REQ-023 Reset asserted mid-stall SHALL discard all held entries; none SHALL reappear after release.

Configuration
REQ-024 Macro EX_MEM_PIPE_SKID_EN defined: two entries (head + skid); ready_o SHALL be registered and equal to "skid empty", with no combinational path from ready_i to ready_o.
REQ-025 Macro EX_MEM_PIPE_SKID_EN undefined: one entry; ready_o = !valid_o || ready_i (combinational); state TWO SHALL be unreachable.

Structure
REQ-026 Package ex_mem_pkg SHALL hold:
- the ctrl struct typedef (regwrite, memtoreg, memread, memwrite);
- the bit-index constants;
- the occupancy-state enum;
- the default XLEN/REG_AW constants.
REQ-027 Sub-module ex_mem_slot (one payload register with load enable and valid clear) SHALL be instantiated once, or twice when the skid is enabled.

Verification
REQ-028 Stream in 4 instructions with ready_i=1 constantly -> 4 outputs on consecutive cycles, each 1 cycle after its input, with no bubble.
REQ-029 Accept alu_result=0x0000_1000 and ctrl=4'b1010, then hold ready_i=0 for 3 cycles -> outputs stable; with skid: one further accept, then ready_o=0; without skid: ready_o=0 immediately.
REQ-030 Skid full {A,B}, then ready_i=1 for 2 cycles -> A then B drained in order; ready_o returns to 1 the cycle after A drains.
REQ-031 flush_i=1 with valid_i=1 and 2 entries held -> next cycle valid_o=0, ctrl_o=0, and the offered instruction is never output.
REQ-032 rst_i pulsed asynchronously between edges while in state ONE -> valid_o=0 and all outputs 0 immediately; ready_o=1 after release.
REQ-033 XLEN=64, REG_AW=6, rs2_data=0xFFFF_FFFF_0000_0001, rd=6'd63 -> mem_data_o and rd_addr_o match bit-exactly.
